// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding and ALU function-code width.
package alu_arbiter_pkg;

    localparam int FN_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// 4-bit combinational ALU shared by the arbiter; function code F selects the operation.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0]    A,
    input  logic [W-1:0]    B,
    input  logic [FN_W-1:0] F,
    output logic [W-1:0]    Y
);

    // 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 A<<1, 111 signed A<B
    always_comb begin
        Y = '0;
        unique case (F)
            3'd0: Y = A + B;
            3'd1: Y = A - B;
            3'd2: Y = A & B;
            3'd3: Y = A | B;
            3'd4: Y = A ^ B;
            3'd5: Y = ~A;
            3'd6: Y = {A[W-2:0], 1'b0};
            3'd7: Y = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
            default: Y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters; results are tagged and held.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [FN_W-1:0]  req0_f,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [FN_W-1:0]  req1_f,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [W-1:0]     res_y,
    output logic             res_id,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    state_e            state_q, state_d;
    logic [W-1:0]      op_a_q, op_a_d;
    logic [W-1:0]      op_b_q, op_b_d;
    logic [FN_W-1:0]   op_f_q, op_f_d;
    logic              gnt_id_q, gnt_id_d;
    logic              last_grant_q, last_grant_d;
    logic              res_valid_q, res_valid_d;
    logic [W-1:0]      res_y_q, res_y_d;
    logic              res_id_q, res_id_d;
    logic [CNT_W-1:0]  done_count_q, done_count_d;
    logic [W-1:0]      alu_y;
    logic              grant0, grant1;

    alu_arbiter_alu #(.W(W)) u_alu (
        .A (op_a_q),
        .B (op_b_q),
        .F (op_f_q),
        .Y (alu_y)
    );

    // On a tie the requester that did not win last time gets the grant.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = rst_n && (state_q == IDLE) && grant0;
    assign req1_ready = rst_n && (state_q == IDLE) && grant1;
    assign res_valid  = rst_n && res_valid_q;
    assign res_y      = res_y_q;
    assign res_id     = res_id_q;
    assign busy       = (state_q != IDLE);
    assign done_count = done_count_q;

    // NOTE: every _d starts as its _q so paths that leave a register alone never infer a latch.
    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_f_d       = op_f_q;
        gnt_id_d     = gnt_id_q;
        last_grant_d = last_grant_q;
        res_valid_d  = res_valid_q;
        res_y_d      = res_y_q;
        res_id_d     = res_id_q;
        done_count_d = done_count_q;

        unique case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    op_a_d       = req1_ready ? req1_a : req0_a;
                    op_b_d       = req1_ready ? req1_b : req0_b;
                    op_f_d       = req1_ready ? req1_f : req0_f;
                    gnt_id_d     = req1_ready;
                    last_grant_d = req1_ready;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                res_y_d     = alu_y;
                res_id_d    = gnt_id_q;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d  = 1'b0;
                    done_count_d = done_count_q + CNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_f_q       <= '0;
            gnt_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            res_valid_q  <= 1'b0;
            res_y_q      <= '0;
            res_id_q     <= 1'b0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_f_q       <= op_f_d;
            gnt_id_q     <= gnt_id_d;
            last_grant_q <= last_grant_d;
            res_valid_q  <= res_valid_d;
            res_y_q      <= res_y_d;
            res_id_q     <= res_id_d;
            done_count_q <= done_count_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed phases plus random traffic against a behavioural model.
module tb_alu_arbiter;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [W-1:0]     req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_f, req1_f;
    logic             req0_ready, req1_ready;
    logic             res_valid;
    logic [W-1:0]     res_y;
    logic             res_id;
    logic             res_ready;
    logic             busy;
    logic [CNT_W-1:0] done_count;

    alu_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_f     (req0_f),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_f     (req1_f),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_y      (res_y),
        .res_id     (res_id),
        .res_ready  (res_ready),
        .busy       (busy),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU computed with plain integer arithmetic on 4-bit values.
    function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
        int ia, ib, sa, sb, r;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 8) ? ia - 16 : ia;
        sb = (ib >= 8) ? ib - 16 : ib;
        case (f)
            3'd0: r = ia + ib;
            3'd1: r = ia - ib + 16;
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = ia ^ ib;
            3'd5: r = 15 - ia;
            3'd6: r = ia * 2;
            default: r = (sa < sb) ? 1 : 0;
        endcase
        return 4'(r % 16);
    endfunction

    typedef struct {
        logic       id;
        logic [3:0] y;
        int         acc;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       e;
    int         cyc        = 0;
    int         model_done = 0;
    logic       last_win_m = 1'b1;
    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [3:0] prev_y     = '0;
    logic       prev_id    = 1'b0;
    logic       win;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: predicts results at each accept, checks them when the DUT presents them.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_quiet", int'({req0_ready, req1_ready, res_valid}), 0);
            sb_q.delete();
            last_win_m = 1'b1;
            model_done = 0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (req0_ready || req1_ready) begin
                check("one_ready", int'(req0_ready & req1_ready), 0);
                check("ready_needs_valid", int'((req0_ready & !req0_valid) | (req1_ready & !req1_valid)), 0);
                if (req0_valid && req1_valid)
                    check("rr_winner", int'(req1_ready), int'(!last_win_m));
                win = req1_ready;
                e.id  = win;
                e.y   = win ? alu_model(req1_a, req1_b, req1_f) : alu_model(req0_a, req0_b, req0_f);
                e.acc = cyc;
                sb_q.push_back(e);
                last_win_m = win;
            end
            if (res_valid) begin
                check("no_ready_in_hold", int'({req0_ready, req1_ready}), 0);
                check("busy_in_hold", int'(busy), 1);
                if (prev_valid && !prev_hs) begin
                    check("hold_res_y", int'(res_y), int'(prev_y));
                    check("hold_res_id", int'(res_id), int'(prev_id));
                end else if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got res_valid=1 y=%0d expected no pending op (t=%0t)", res_y, $time);
                end else begin
                    check("latency", cyc - sb_q[0].acc, 2);
                end
                if (res_ready && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("res_y", int'(res_y), int'(e.y));
                    check("res_id", int'(res_id), int'(e.id));
                    check("done_count", int'(done_count), model_done % (1 << CNT_W));
                    model_done++;
                end
            end
            prev_valid = res_valid;
            prev_hs    = res_valid && res_ready;
            prev_y     = res_y;
            prev_id    = res_id;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_res(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_ready(input string name, input bit which, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which ? req1_ready : req0_ready)) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    int   ids[4];
    int   acc_cyc[4];
    int   n_acc;
    bit   hs0, hs1;

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_f = '0;
        req1_a = '0; req1_b = '0; req1_f = '0;
        res_ready  = 1'b1;

        // Reset with both valids high.
        tick();
        repeat (2) begin
            @(negedge clk);
            check("rst_readys", int'({req0_ready, req1_ready}), 0);
            check("rst_res_valid", int'(res_valid), 0);
            check("rst_done_count", int'(done_count), 0);
            check("rst_busy", int'(busy), 0);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        tick();

        // Single request from requester 0.
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_f = 3'd0;
        @(negedge clk);
        check("single_ready0", int'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("single_n1_res_valid", int'(res_valid), 0);
        check("single_n1_busy", int'(busy), 1);
        tick();
        @(negedge clk);
        check("single_n2_res_valid", int'(res_valid), 1);
        check("single_res_y", int'(res_y), 3);
        check("single_res_id", int'(res_id), 0);
        tick();
        @(negedge clk);
        check("single_done_count", int'(done_count), 1);
        check("single_idle", int'(busy), 0);

        // Contention: both valids held for four operations.
        tick();
        do_reset(1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'($urandom); req0_b = 4'($urandom); req0_f = 3'($urandom);
        req1_a = 4'($urandom); req1_b = 4'($urandom); req1_f = 3'($urandom);
        n_acc = 0;
        for (int i = 0; i < 40 && n_acc < 4; i++) begin
            @(negedge clk);
            hs0 = req0_ready;
            hs1 = req1_ready;
            if (hs0 || hs1) begin
                ids[n_acc]     = hs1 ? 1 : 0;
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            tick();
            if (hs0) begin req0_a = 4'($urandom); req0_b = 4'($urandom); req0_f = 3'($urandom); end
            if (hs1) begin req1_a = 4'($urandom); req1_b = 4'($urandom); req1_f = 3'($urandom); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("contend_accepts", n_acc, 4);
        for (int i = 0; i < 4; i++) check("contend_order", ids[i], i % 2);
        for (int i = 1; i < 4; i++) check("contend_interval", acc_cyc[i] - acc_cyc[i-1], 3);
        repeat (4) tick();

        // Backpressure on the result side.
        res_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 4'($urandom); req1_b = 4'($urandom); req1_f = 3'($urandom);
        wait_ready("bp_accept", 1'b1, 10);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd4; req0_f = 3'd1;
        wait_res("bp_res", 10);
        tick();
        repeat (5) begin
            @(negedge clk);
            check("bp_res_valid", int'(res_valid), 1);
            check("bp_readys", int'({req0_ready, req1_ready}), 0);
            check("bp_busy", int'(busy), 1);
            tick();
        end
        res_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_back_idle", int'(busy), 0);
        check("bp_next_grant", int'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        repeat (5) tick();

        // Reset while the operation is in EXEC.
        do_reset(1);
        req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd3; req0_f = 3'd4;
        wait_ready("midrst_accept", 1'b0, 5);
        tick();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("midrst_no_result", int'(res_valid), 0);
            tick();
        end
        @(negedge clk);
        check("midrst_done_count", int'(done_count), 0);
        check("midrst_idle", int'(busy), 0);
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("midrst_last_grant", int'({req0_ready, req1_ready}), 2);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (5) tick();

        // Function sweep through requester 1.
        do_reset(1);
        for (int f = 0; f < 8; f++) begin
            req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd2; req1_f = 3'(f);
            wait_ready("sweep_accept", 1'b1, 5);
            tick();
            req1_valid = 1'b0;
            wait_res("sweep_res", 5);
            check("sweep_res_y", int'(res_y), int'(alu_model(4'd1, 4'd2, 3'(f))));
            check("sweep_res_id", int'(res_id), 1);
            tick();
        end
        @(negedge clk);
        check("sweep_done_count", int'(done_count), 8);
        tick();

        // Random traffic long enough to wrap done_count.
        begin
            int i;
            for (i = 0; i < 4000 && model_done < 300; i++) begin
                @(negedge clk);
                hs0 = req0_valid && req0_ready;
                hs1 = req1_valid && req1_ready;
                tick();
                if (hs0 || !req0_valid) begin
                    req0_valid = ($urandom_range(0, 2) != 0);
                    req0_a = 4'($urandom); req0_b = 4'($urandom); req0_f = 3'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    req0_valid = 1'b0;
                end
                if (hs1 || !req1_valid) begin
                    req1_valid = ($urandom_range(0, 2) != 0);
                    req1_a = 4'($urandom); req1_b = 4'($urandom); req1_f = 3'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    req1_valid = 1'b0;
                end
                res_ready = ($urandom_range(0, 3) != 0);
            end
            check("random_progress", int'(model_done >= 300), 1);
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        check("final_done_count", int'(done_count), model_done % (1 << CNT_W));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one instance of the existing 4-bit combinational ALU (ports A, B, F, Y) between two requesters. Uses round-robin arbitration and valid/ready handshakes on both sides.
Each accepted request has its operands registered, runs through the ALU for one cycle, and returns the result tagged with the requester ID. The result is held until the consumer accepts it.
Sits between two operation sources (e.g. a sequencer and a test port) and one result consumer.

Parameters:
W, 4, operand/result width; must match the ALU (4).
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active low
req0_valid  in  1  requester 0 has an operation pending
req0_a  in  W  requester 0 operand A
req0_b  in  W  requester 0 operand B
req0_f  in  3  requester 0 ALU function code (passed to F unchanged)
req0_ready  out  1  requester 0 operation accepted this cycle
req1_valid, req1_a, req1_b, req1_f, req1_ready: same as requester 0, for requester 1
res_valid  out  1  result available
res_y  out  W  ALU result Y
res_id  out  1  requester that issued the result (0/1)
res_ready  in  1  consumer accepts the result
busy  out  1  high in any state other than IDLE
done_count  out  CNT_W  number of completed result handshakes, wraps modulo 2^CNT_W

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset values: state=IDLE, res_valid=0, res_y=0, res_id=0, done_count=0, operand regs=0, last_grant=1 (so requester 0 wins the first tie).
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - req0_ready and req1_ready are combinational from the valids and last_grant.
  - If exactly one valid is high, that requester is granted.
  - If both are high, the requester != last_grant is granted.
  - At most one ready is high in any cycle. Both readys are 0 outside IDLE.
  - On handshake (valid & ready): latch a, b, f into op regs, latch the grant into gnt_id, set last_grant=gnt_id, go to EXEC.
- EXEC: ALU inputs are driven from the op regs. At the end of the cycle, res_y<=Y, res_id<=gnt_id, res_valid<=1, go to HOLD.
- HOLD:
  - res_valid=1; res_y and res_id are held stable.
  - On res_valid & res_ready: res_valid<=0, done_count<=done_count+1, go to IDLE.
- Latency: handshake in cycle N gives res_valid high from cycle N+2. Minimum issue interval is 3 cycles when res_ready is tied high.
- No new request is accepted in the same cycle as a result handshake; the next grant is in the following IDLE cycle.
- Requesters must hold payload stable while valid and not ready. Payload is sampled only at the handshake.
- A requester dropping valid before being granted is legal; nothing is recorded for it.
- Arithmetic: the block does not interpret F. Width and overflow behaviour are the ALU's own.
- done_count wraps from 2^CNT_W-1 to 0.
- Reset mid-operation (rst_n=0 in EXEC or HOLD): the in-flight operation is discarded with no result handshake, and all registers return to their reset values on that edge.
- While rst_n=0, both readys and res_valid are 0.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, EXEC=2'd1, HOLD=2'd2) and the ALU function-code width constant (3).
- Sub-module: the existing ALU is instantiated unchanged as the datapath.
- Arbitration is small enough to live inline. Optionally split it out as rr_arb2 (inputs: two valids, last_grant, enable; outputs: one-hot grant).

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with both valids high -> readys=0, res_valid=0, done_count=0, busy=0.
2. Single request: req0 A=1, B=2, F=000, res_ready=1 -> req0_ready in cycle N, res_valid in N+2 with res_y equal to the ALU model for (1,2,000), res_id=0, done_count=1.
3. Contention: both valids held high for 4 operations, res_ready=1 -> grants alternate 0,1,0,1; accepts every 3 cycles; res_id follows the same order.
4. Backpressure: res_ready=0 for 5 cycles after res_valid -> res_y and res_id stable, both readys 0, busy=1. Then res_ready=1 -> handshake and return to IDLE.
5. Reset mid-op: assert rst_n=0 in EXEC -> no res_valid ever appears for that operation, done_count stays unchanged at 0, last_grant=1.
6. Sweep F=000..111 with A=1, B=2 through requester 1 -> every res_y matches the ALU model; done_count=8.
